// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file geometry, load funct3 codes, the
// write-back entry record and the load byte/halfword extension helper.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Halfword lane ignores addr_lo[0]; unknown load types behave as LW.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] word,
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo
    );
        logic [7:0]      byte_v;
        logic [15:0]     half_v;
        logic [XLEN-1:0] res;
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   res = {{24{byte_v[7]}}, byte_v};
            F3_LH:   res = {{16{half_v[15]}}, half_v};
            F3_LW:   res = word;
            F3_LBU:  res = {24'h000000, byte_v};
            F3_LHU:  res = {16'h0000, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of ALU result, load-beat handshake, load-issue and register-file
// write-port signals of the write-back front end.
interface regfile_writeback_if;
    import riscv_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic [2:0]            mem_funct3;
    logic [1:0]            mem_addr_lo;
    logic                  load_issue;
    logic [REG_ADDR_W-1:0] load_issue_rd;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [31:0]           busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
        input  load_issue, load_issue_rd,
        output mem_ready, RegWrite, rd, data, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
        output load_issue, load_issue_rd,
        input  mem_ready, RegWrite, rd, data, busy
    );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// wb_fifo: small synchronous FIFO of {rd, data} write-back entries with
// async active-high reset; push while full and pop while empty are ignored.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output wb_entry_t rd_entry,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == (PTR_W+1)'(0));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign rd_entry = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back front end: ALU/load arbitration, load extension,
// load FIFO and pending-load scoreboard. Optional REGFILE_WB_BYPASS_EN.
module regfile_writeback
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    regfile_writeback_if.slave  wb
);
`ifdef REGFILE_WB_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    wb_entry_t             beat_entry;
    wb_entry_t             head_entry;
    wb_entry_t             src_entry;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic                  accept, bypass_take;
    logic                  src_valid, src_is_load;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [31:0]           busy_q, busy_d;

    // Load handshake, extension and FIFO-versus-bypass steering.
    always_comb begin
        accept          = wb.mem_valid && !fifo_full;
        beat_entry.rd   = wb.mem_rd;
        beat_entry.data = load_extend(wb.mem_data, wb.mem_funct3, wb.mem_addr_lo);
        bypass_take     = BYPASS_EN && accept && fifo_empty && !wb.alu_valid;
        fifo_pop        = !wb.alu_valid && !fifo_empty;
        fifo_push       = accept && !bypass_take;
    end

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (beat_entry),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Source priority: ALU, FIFO head, bypassed beat; rd=0 writes are consumed silently.
    always_comb begin
        src_valid   = 1'b0;
        src_is_load = 1'b0;
        src_entry   = '0;
        if (wb.alu_valid) begin
            src_valid      = 1'b1;
            src_entry.rd   = wb.alu_rd;
            src_entry.data = wb.alu_data;
        end else if (fifo_pop) begin
            src_valid   = 1'b1;
            src_is_load = 1'b1;
            src_entry   = head_entry;
        end else if (bypass_take) begin
            src_valid   = 1'b1;
            src_is_load = 1'b1;
            src_entry   = beat_entry;
        end else begin
            src_valid = 1'b0;
        end

        reg_write_d = 1'b0;
        rd_d        = rd_q;
        data_d      = data_q;
        if (src_valid && (src_entry.rd != 5'd0)) begin
            reg_write_d = 1'b1;
            rd_d        = src_entry.rd;
            data_d      = src_entry.data;
        end else begin
            reg_write_d = 1'b0;
        end

        // Set is applied after clear so a same-cycle re-issue keeps the bit.
        busy_d = busy_q;
        if (src_is_load) begin
            busy_d[src_entry.rd] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (wb.load_issue && (wb.load_issue_rd != 5'd0)) begin
            busy_d[wb.load_issue_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            data_q      <= 32'h0000_0000;
            busy_q      <= 32'h0000_0000;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign wb.mem_ready = !fifo_full;
    assign wb.RegWrite  = reg_write_q;
    assign wb.rd        = rd_q;
    assign wb.data      = data_q;
    assign wb.busy      = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: extension vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_regfile_writeback;
    import riscv_pkg::*;

    localparam int DEPTH = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP      = 1'b1;
    localparam int LOAD_LAT = 1;
`else
    localparam bit BYP      = 1'b0;
    localparam int LOAD_LAT = 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if wb_if ();

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pending loads in arrival order plus expected outputs.
    wb_entry_t   m_q [$];
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [4:0]  wr_log [$];

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] word;
        logic [31:0] exp;
    } ext_vec_t;
    ext_vec_t vt [10];

    function automatic logic [31:0] ref_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b > 32'h7F)   ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h > 32'h7FFF) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 32'h0;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_data = 32'h0;
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic [2:0] f3, input logic [1:0] alo,
                        input logic li, input logic [4:0] lird, output logic acc);
        logic      ready, byp, have, isld;
        logic [31:0] ext;
        wb_entry_t e;
        wb_if.alu_valid     = av;
        wb_if.alu_rd        = ard;
        wb_if.alu_data      = adat;
        wb_if.mem_valid     = mv;
        wb_if.mem_rd        = mrd;
        wb_if.mem_data      = mdat;
        wb_if.mem_funct3    = f3;
        wb_if.mem_addr_lo   = alo;
        wb_if.load_issue    = li;
        wb_if.load_issue_rd = lird;
        ready = (m_q.size() < DEPTH);
        check("mem_ready", {31'h0, wb_if.mem_ready}, {31'h0, ready});
        acc  = mv && ready;
        ext  = ref_ext(mdat, f3, alo);
        byp  = BYP && acc && (m_q.size() == 0) && !av;
        have = 1'b0;
        isld = 1'b0;
        e    = '{rd: 5'd0, data: 32'h0};
        if (av) begin
            have = 1'b1;
            e    = '{rd: ard, data: adat};
        end else if (m_q.size() > 0) begin
            have = 1'b1;
            isld = 1'b1;
            e    = m_q.pop_front();
        end else if (byp) begin
            have = 1'b1;
            isld = 1'b1;
            e    = '{rd: mrd, data: ext};
        end
        if (have && isld) m_busy[e.rd] = 1'b0;
        m_we = 1'b0;
        if (have && e.rd != 5'd0) begin
            m_we   = 1'b1;
            m_rd   = e.rd;
            m_data = e.data;
        end
        if (acc && !byp) m_q.push_back('{rd: mrd, data: ext});
        if (li && lird != 5'd0) m_busy[lird] = 1'b1;
        m_busy[0] = 1'b0;
        @(posedge clk);
        #1;
        check("RegWrite", {31'h0, wb_if.RegWrite}, {31'h0, m_we});
        check("rd", {27'h0, wb_if.rd}, {27'h0, m_rd});
        check("data", wb_if.data, m_data);
        check("busy", wb_if.busy, m_busy);
        if (wb_if.RegWrite === 1'b1) wr_log.push_back(wb_if.rd);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          lat;
        int          bi;
        logic [4:0]  exp_order [7];

        wb_if.alu_valid = 1'b0; wb_if.alu_rd = 5'd0; wb_if.alu_data = 32'h0;
        wb_if.mem_valid = 1'b0; wb_if.mem_rd = 5'd0; wb_if.mem_data = 32'h0;
        wb_if.mem_funct3 = 3'd0; wb_if.mem_addr_lo = 2'd0;
        wb_if.load_issue = 1'b0; wb_if.load_issue_rd = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_we", {31'h0, wb_if.RegWrite}, 32'h0);
        check("rst_rd", {27'h0, wb_if.rd}, 32'h0);
        check("rst_data", wb_if.data, 32'h0);
        check("rst_busy", wb_if.busy, 32'h0);
        check("rst_ready", {31'h0, wb_if.mem_ready}, 32'h1);

        // ALU latency
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0, acc);
        check("alu_we", {31'h0, wb_if.RegWrite}, 32'h1);
        check("alu_rd", {27'h0, wb_if.rd}, 32'd5);
        check("alu_data", wb_if.data, 32'hDEAD_BEEF);
        idle(1);
        check("alu_we_after", {31'h0, wb_if.RegWrite}, 32'h0);

        // Extension table
        vt[0] = '{3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F};
        vt[1] = '{3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vt[2] = '{3'b101, 2'd2, 32'h80FF_7F01, 32'h0000_80FF};
        vt[3] = '{3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF};
        vt[4] = '{3'b010, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01};
        vt[5] = '{3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
        vt[6] = '{3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF};
        vt[7] = '{3'b001, 2'd0, 32'h80FF_7F01, 32'h0000_7F01};
        vt[8] = '{3'b011, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01};
        vt[9] = '{3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        foreach (vt[i]) begin
            step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, vt[i].word, vt[i].f3, vt[i].alo, 1'b0, 5'd0, acc);
            lat = 1;
            while (wb_if.RegWrite !== 1'b1 && lat < 5) begin
                idle(1);
                lat++;
            end
            check("ext_data", wb_if.data, vt[i].exp);
            check("ext_latency", lat, LOAD_LAT);
        end

        // ALU starvation with three beats into a two-entry FIFO
        idle(2);
        wr_log.delete();
        exp_order = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd11, 5'd12};
        bi = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) check("ready_low_full", {31'h0, wb_if.mem_ready}, 32'h0);
            step(c < 4, 5'(20 + c), 32'h1000 + c, bi < 3, 5'(10 + bi), 32'hA000 + bi,
                 3'b010, 2'd0, 1'b0, 5'd0, acc);
            if (acc) bi++;
        end
        check("starve_count", wr_log.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < wr_log.size()) check("starve_order", {27'h0, wr_log[k]}, {27'h0, exp_order[k]});
        end

        // Scoreboard
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b1, 5'd7, acc);
        check("busy7_set", {31'h0, wb_if.busy[7]}, 32'h1);
        idle(2);
        check("busy7_hold", {31'h0, wb_if.busy[7]}, 32'h1);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234_5678, 3'b010, 2'd0, 1'b0, 5'd0, acc);
        lat = 1;
        while (!(wb_if.RegWrite === 1'b1 && wb_if.rd == 5'd7) && lat < 5) begin
            idle(1);
            lat++;
        end
        check("busy7_wb_seen", {31'h0, wb_if.RegWrite}, 32'h1);
        check("busy7_clr", {31'h0, wb_if.busy[7]}, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b1, 5'd0, acc);
        check("busy0_never", wb_if.busy, 32'h0);

        // Writes to x0 are dropped and the FIFO still drains
        step(1'b1, 5'd0, 32'h5555_5555, 1'b1, 5'd0, 32'h1, 3'b010, 2'd0, 1'b0, 5'd0, acc);
        check("x0_alu_we", {31'h0, wb_if.RegWrite}, 32'h0);
        step(1'b1, 5'd0, 32'h6666_6666, 1'b1, 5'd0, 32'h2, 3'b010, 2'd0, 1'b0, 5'd0, acc);
        check("x0_alu_we2", {31'h0, wb_if.RegWrite}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("x0_load_we", {31'h0, wb_if.RegWrite}, 32'h0);
        end
        check("x0_drained", {31'h0, wb_if.mem_ready}, 32'h1);

        // Async reset with two buffered loads and a busy bit
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99, 3'b010, 2'd0, 1'b1, 5'd9, acc);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hAA, 3'b010, 2'd0, 1'b1, 5'd10, acc);
        check("pre_rst_full", {31'h0, wb_if.mem_ready}, 32'h0);
        wb_if.alu_valid = 1'b0; wb_if.mem_valid = 1'b0; wb_if.load_issue = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", {31'h0, wb_if.RegWrite}, 32'h0);
        check("arst_rd", {27'h0, wb_if.rd}, 32'h0);
        check("arst_data", wb_if.data, 32'h0);
        check("arst_busy", wb_if.busy, 32'h0);
        check("arst_ready", {31'h0, wb_if.mem_ready}, 32'h1);
        model_reset();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_we", {31'h0, wb_if.RegWrite}, 32'h0);
        wr_log.delete();
        idle(4);
        check("no_stale_write", wr_log.size(), 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), acc);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the core's 32×32 register file. Merges single-cycle ALU results and handshaked load results from the data-memory interface into one registered write port (`RegWrite`/`rd`/`data`) that drives the register file directly. Performs load byte/halfword extraction and sign/zero extension, buffers load results in a small FIFO, and keeps a pending-load scoreboard for the hazard unit.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: load-result buffer entries, power of two, ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  load beat offered.
- `mem_ready`  out  1  load beat accepted when `mem_valid && mem_ready`.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  raw aligned memory word.
- `mem_funct3`  in  3  load type.
- `mem_addr_lo`  in  2  byte offset of load address.
- `load_issue`  in  1  load issued by execute stage this cycle.
- `load_issue_rd`  in  5  destination of issued load.
- `RegWrite`  out  1  register-file write enable, registered.
- `rd`  out  5  register-file write address, registered.
- `data`  out  32  register-file write data, registered.
- `busy`  out  32  bit i = load to xi outstanding, registered.

## Operation
- Output register source priority each cycle: (1) ALU if `alu_valid`; (2) FIFO head, if non-empty (pop); (3) incoming load beat via bypass (only with `WB_BYPASS_EN`, FIFO empty, `alu_valid=0`); (4) idle: `RegWrite=0`, `rd`/`data` hold.
- Accepted load beats not taken by bypass are pushed into the FIFO after extension.
- `mem_ready = !fifo_full`. Pop in the same cycle does not raise ready; no push while full.
- Extension: `000` LB, `001` LH, `010` LW, `100` LBU, `101` LHU. Byte lane = `mem_data[8*addr_lo +: 8]`; halfword lane = `mem_data[16*addr_lo[1] +: 16]`, `addr_lo[0]` ignored. Other funct3 values are treated as LW.
- A write with destination 0 is dropped: the source is consumed, and `RegWrite=0` for that cycle.
- Scoreboard:
  - Set `busy[load_issue_rd]` on `load_issue` when rd≠0.
  - Clear it when the output register is loaded from the load path (FIFO or bypass) for that rd.
  - Same-cycle set and clear of the same bit: set wins.
  - `busy[0]` is always 0.
- ALU and load results to the same rd in the same cycle: ALU writes first, and the load writes in a later cycle. This order is intended; the hazard unit prevents the case architecturally.

## Timing
- Reset (async assert, sync release): `RegWrite=0`, `rd=0`, `data=0`, `busy=0`, FIFO empty, `mem_ready=1`.
- Reset mid-operation discards all buffered loads and clears all `busy` bits immediately.
- ALU latency: `alu_valid` at cycle N gives `RegWrite=1` in cycle N+1.
- Load latency: beat accepted at N.
  - With bypass, FIFO empty and no ALU: write in cycle N+1.
  - Otherwise, FIFO path: earliest write in cycle N+2, plus one cycle per ALU result or older FIFO entry ahead of it.
- Sustained `alu_valid=1` starves the FIFO indefinitely. `mem_ready` falls after `FIFO_DEPTH` buffered beats.
- `busy` update is visible the cycle after `load_issue`, and clears the same cycle `RegWrite` for the load appears.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: priority (3) is active. A load beat arriving with the FIFO empty and no ALU result skips the FIFO, giving 1-cycle latency.
- Undefined: every load beat passes through the FIFO, giving a minimum 2-cycle latency. Ports are unchanged.

## Structure
- Shared package `riscv_pkg`:
  - Load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
  - `REG_ADDR_W=5`, `XLEN=32`.
  - Typedef of a write-back entry `{rd, data}`.
- Sub-module `wb_fifo`: parameterized synchronous FIFO of `{rd[4:0], data[31:0]}` with push/pop/full/empty, async active-high reset. Extension logic and arbitration remain in the top level.

## Test plan
- Reset, then `alu_valid=1`, `alu_rd=5`, `alu_data=0xDEADBEEF` at N → cycle N+1 shows `RegWrite=1`, `rd=5`, `data=0xDEADBEEF`; cycle N+2 shows `RegWrite=0`.
- Load beat `mem_data=0x80FF7F01`, `mem_rd=3`:
  - LB, `addr_lo=1` → `0x0000007F`.
  - LB, `addr_lo=2` → `0xFFFFFFFF`.
  - LHU, `addr_lo=2` → `0x000080FF`.
  - LH, `addr_lo=2` → `0xFFFF80FF`.
- `alu_valid` held for 4 cycles while 3 load beats arrive (depth 2):
  - `mem_ready` drops after the 2nd beat.
  - ALU writes all appear first, then the loads in order.
  - No beat is lost.
- `load_issue` with `load_issue_rd=7` → `busy[7]=1` from the next cycle; clears with its write-back. `load_issue_rd=0` never sets `busy`.
- ALU write to rd=0 and load to rd=0 → `RegWrite` stays 0; the FIFO drains.
- Async `reset` pulse while the FIFO holds 2 entries → outputs zero immediately, `mem_ready=1`, no stale write after release. Run under both macro settings: bypass latency is 1 cycle when defined, 2 cycles when undefined.
